// File: rtl/mux_word_sel_if.sv
// Request/response bus for mux_word_sel: producer side (in_*) and consumer side (out_*).
// master = producer/consumer environment, slave = the mux block.
interface mux_word_sel_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_bit;
  logic                    out_last;
  logic                    out_err;

  modport master (
    output in_data, in_sel, in_mode, in_valid, out_ready,
    input  in_ready, out_valid, out_data, out_bit, out_last, out_err
  );

  modport slave (
    input  in_data, in_sel, in_mode, in_valid, out_ready,
    output in_ready, out_valid, out_data, out_bit, out_last, out_err
  );
endinterface

// File: rtl/mux_word_sel.sv
// Registered N:1 word mux with valid/ready handshake; optionally serialises the
// selected word MSB-first, one bit per accepted beat.
module mux_word_sel #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4
) (
  input  logic         clk,
  input  logic         rst,
  mux_word_sel_if.slave bus
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, WORD, SHIFT} state_t;

  state_t           state;
  logic             mode_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic             done;
  logic             accept;

  // Word 0 sits in the most significant slot; out-of-range selects yield zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (bus.in_sel == SEL_W'(k))
        sel_word = bus.in_data[(NUM_IN-1-k)*WIDTH +: WIDTH];
  end

  assign sel_err = ({1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_IN));

  // Completion frees the slot in the same cycle so requests chain without a bubble.
  assign done         = bus.out_valid & bus.out_ready & (~mode_q | bus.out_last);
  assign bus.in_ready = (state == IDLE) | done;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_bit  = shift_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      shift_q       <= '0;
      cnt_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      state         <= bus.in_mode ? SHIFT : WORD;
      mode_q        <= bus.in_mode;
      shift_q       <= sel_word;
      cnt_q         <= CNT_W'(WIDTH-1);
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_word;
      bus.out_last  <= bus.in_mode & (WIDTH == 1);
      bus.out_err   <= sel_err;
    end else if (done) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (state == SHIFT && bus.out_ready) begin
      shift_q      <= shift_q << 1;
      cnt_q        <= cnt_q - 1'b1;
      bus.out_last <= (cnt_q == CNT_W'(1));
    end
  end
endmodule
